// File: rtl/wb_retire_stage_pkg.sv
// wb_retire_stage_pkg
// Shared types for the writeback/retire stage: datapath word and register
// index types, the retire-FSM state encoding and the writeback source select.
// No ports (package).
package wb_retire_stage_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } wb_state_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_IMM = 2'b11
    } wb_src_t;

    // Drain counter width; covers the legal DRAIN_CYC range 1..15.
    localparam int DRAIN_CNT_W = 4;

endpackage

// File: rtl/wb_retire_stage_halt_fsm.sv
// wb_halt_fsm
// Halt sequencing for the retire stage. A valid halt slot moves RUN->DRAIN,
// DRAIN counts down DRAIN_CYC cycles, then HALTED holds until reset.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   slot_v    : WB slot valid (not a bubble)
//   halt_i    : halt instruction in WB
//   run       : combinational, state is RUN
//   halt      : registered, state is HALTED (one edge behind the state)
module wb_halt_fsm
    import wb_retire_stage_pkg::*;
#(
    parameter int DRAIN_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic slot_v,
    input  logic halt_i,
    output logic run,
    output logic halt
);

    wb_state_t              state_q, state_d;
    logic [DRAIN_CNT_W-1:0] cnt_q, cnt_d;
    logic                   halt_q, halt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        // Registered from the current state so halt trails HALTED by one edge.
        halt_d  = (state_q == HALTED);
        case (state_q)
            RUN: begin
                if (slot_v && halt_i) begin
                    state_d = DRAIN;
                    cnt_d   = DRAIN_CNT_W'(DRAIN_CYC - 1);
                end
            end
            DRAIN: begin
                if (cnt_q == '0) state_d = HALTED;
                else             cnt_d   = cnt_q - 1'b1;
            end
            HALTED: ;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            halt_q  <= halt_d;
        end
    end

    assign run  = (state_q == RUN);
    assign halt = halt_q;

endmodule

// File: rtl/wb_retire_stage.sv
// wb_retire_stage
// Writeback/retire stage fed by the MEM/WB pipeline register. Selects the
// writeback word, drives the register-file write port with zero latency,
// keeps a registered copy of the last write for EX forwarding, and
// sequences processor halt through wb_halt_fsm.
// Optional feature macro: WB_RETIRE_CNT_EN adds the retire_cnt port/counter.
// Ports:
//   CLK, RST                    : clock, synchronous active-high reset
//   imm_i/pc4_i/OutputPort_i/
//   dmemload_i                  : candidate writeback words
//   wsel_i, RegWr_i, MemToReg_i : destination, write request, source select
//   halt_i, stopread_i          : halt in WB, bubble marker (1 = invalid)
//   WEN, wsel, wdat             : register-file write port
//   fwd_valid/fwd_sel/fwd_data  : registered last write for forwarding
//   halt                        : sticky halt
//   retire_cnt                  : retired instruction count (optional)
module wb_retire_stage
    import wb_retire_stage_pkg::*;
#(
    parameter int DRAIN_CYC = 2,
    parameter int CNT_W     = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] imm_i,
    input  logic [31:0] pc4_i,
    input  logic [31:0] OutputPort_i,
    input  logic [31:0] dmemload_i,
    input  logic [4:0]  wsel_i,
    input  logic        RegWr_i,
    input  logic [1:0]  MemToReg_i,
    input  logic        halt_i,
    input  logic        stopread_i,
    output logic        WEN,
    output logic [4:0]  wsel,
    output logic [31:0] wdat,
    output logic        fwd_valid,
    output logic [4:0]  fwd_sel,
    output logic [31:0] fwd_data,
    output logic        halt
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retire_cnt
`endif
);

    logic     slot_v;
    logic     run;
    word_t    wb_word;
    logic     fwd_valid_q, fwd_valid_d;
    regbits_t fwd_sel_q, fwd_sel_d;
    word_t    fwd_data_q, fwd_data_d;

    assign slot_v = ~stopread_i;

    wb_halt_fsm #(.DRAIN_CYC(DRAIN_CYC)) u_halt_fsm (
        .clk    (CLK),
        .rst    (RST),
        .slot_v (slot_v),
        .halt_i (halt_i),
        .run    (run),
        .halt   (halt)
    );

    always_comb begin
        wb_word = OutputPort_i;
        case (wb_src_t'(MemToReg_i))
            WB_ALU:  wb_word = OutputPort_i;
            WB_MEM:  wb_word = dmemload_i;
            WB_PC4:  wb_word = pc4_i;
            WB_IMM:  wb_word = imm_i;
            default: wb_word = OutputPort_i;
        endcase
    end

    // The halt instruction itself never writes; RST masks the port so a
    // reset edge cannot commit a stale slot.
    assign WEN  = run & ~RST & slot_v & RegWr_i & ~halt_i & (wsel_i != 5'd0);
    assign wsel = wsel_i;
    assign wdat = wb_word;

    always_comb begin
        fwd_valid_d = 1'b0;
        fwd_sel_d   = fwd_sel_q;
        fwd_data_d  = fwd_data_q;
        if (run) begin
            fwd_valid_d = WEN;
            fwd_sel_d   = wsel_i;
            fwd_data_d  = wb_word;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fwd_valid_q <= 1'b0;
            fwd_sel_q   <= '0;
            fwd_data_q  <= '0;
        end else begin
            fwd_valid_q <= fwd_valid_d;
            fwd_sel_q   <= fwd_sel_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    assign fwd_valid = fwd_valid_q;
    assign fwd_sel   = fwd_sel_q;
    assign fwd_data  = fwd_data_q;

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    // Every valid slot in RUN retires, including halt and non-writing ops.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (run && slot_v) retire_cnt_d = retire_cnt_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) retire_cnt_q <= '0;
        else     retire_cnt_q <= retire_cnt_d;
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule
